jtag_tap_ctrl: RTL and testbench
================================

Name: jtag_tap_ctrl

Overview:
Full IEEE 1149.1-style TAP controller. It combines the 16-state TAP state machine with a parametrised instruction register, built-in BYPASS and IDCODE data registers, and NUM_USER external user data-register channels. It sits between the chip-level JTAG pins and the internal scan/debug chains. It decodes the instruction and routes capture, shift and update strobes and TDO to the selected data register.

Parameters:
IR_WIDTH, 4, instruction register length in bits (min 2).
IDCODE_VAL, 32'h1000_0001, value captured by the IDCODE DR (bit 0 must be 1).
IDCODE_OP, 4'b0001, IR opcode selecting IDCODE; also the IR value after reset.
NUM_USER, 2, number of external user DR channels (1..8).
USER_OP_BASE, 4'b1000, opcode of user channel 0; channel k uses USER_OP_BASE+k.

Ports:
TCLK  in  1  test clock; all state updates on its rising edge only.
TRSTN  in  1  synchronous active-low reset, sampled on rising TCLK.
TMS  in  1  test mode select.
TDI  in  1  serial data in.
TDO  out  1  serial data out (combinational mux of register LSBs).
TDO_EN  out  1  high in ShiftDR or ShiftIR states only.
tap_state  out  4  current TAP state encoding.
ir_q  out  IR_WIDTH  latched (active) instruction.
user_sel  out  NUM_USER  one-hot select of the active user channel; all zero if none.
CaptureDR, ShiftDR, UpdateDR  out  1 each  state strobes, gated by user_sel != 0.
CaptureIR, ShiftIR, UpdateIR  out  1 each  raw state strobes.
user_tdo  in  NUM_USER  serial out from each user chain.

Behaviour:
- State encoding is fixed:
  - TLR=0, IDLE=1, SelectDR=2, CapDR=3, ShiDR=4, ExitDR1=5, PauseDR=6, ExitDR2=7, UpdDR=8
  - SelectIR=9, CapIR=10, ShiIR=11, ExitIR1=12, PauseIR=13, ExitIR2=14, UpdIR=15
- Transitions follow standard 1149.1. Encoding is 4 bits, so there are no illegal states.
- Rising TCLK with TRSTN=0: state<=TLR, ir_q<=IDCODE_OP, ir_shift<=0, bypass<=0, idcode_shift<=0. This is synchronous and overrides TMS.
- TMS=1 for 5 consecutive TCLK from any state reaches TLR. Every cycle in TLR reloads ir_q<=IDCODE_OP.
- IR path:
  - Clock leaving CapIR: ir_shift<={0..,2'b01}.
  - Each clock in ShiIR: ir_shift shifts right, TDI enters the MSB.
  - Clock in UpdIR: ir_q<=ir_shift.
- Decode from ir_q:
  - all ones: BYPASS.
  - IDCODE_OP: IDCODE.
  - USER_OP_BASE+k, for k<NUM_USER: user k.
  - any other opcode: BYPASS.
- BYPASS: 1-bit register. Captures 0 in CapDR, loads TDI in ShiDR.
- IDCODE: 32-bit register. Loads IDCODE_VAL in CapDR, shifts right with TDI entering bit 31 in ShiDR.
- User channels: user_sel decoded combinationally from ir_q. DR strobes are asserted only while user_sel != 0. The controller holds no user data; the external chain shifts on rising TCLK while ShiftDR=1.
- TDO mux:
  - ShiIR: ir_shift[0].
  - ShiDR: LSB of the selected DR, or user_tdo[k].
  - Otherwise TDO=0.
- Output latency:
  - Strobes, TDO_EN and tap_state are combinational from the state register, valid in the same cycle.
  - ir_q changes the cycle after UpdIR.
- Reset values: tap_state=0, ir_q=IDCODE_OP, user_sel=0 unless IDCODE_OP aliases a user op, all strobes 0, TDO=0, TDO_EN=0.
- Reset mid-shift (TRSTN low in ShiDR or ShiIR): the partial shift is discarded, ir_q is not updated, and the next state is TLR.
- Elaboration checks:
  - IDCODE_OP must not be all ones.
  - USER_OP_BASE+NUM_USER-1 must be below all ones and must not overlap IDCODE_OP; overlap is a fatal error.

Decomposition:
- Package jtag_pkg holds:
  - the tap_state_t enum with the encodings above,
  - BYPASS opcode function all_ones(IR_WIDTH),
  - capture constant IR_CAPTURE=2'b01.
- Sub-module jtag_tap_fsm: the pure state register plus next-state logic, with TCLK, TRSTN and TMS in and the state out.
- The top level holds the IR, BYPASS, IDCODE, decode and TDO mux.

Test Plan:
- TRSTN=0 for 1 clock, then TMS=0: tap_state=1, ir_q=4'b0001. Shift 32 DR bits: TDO emits 32'h1000_0001, LSB first.
- From IDLE, load IR 4'b1111 and shift DR with TDI pattern 1,0,1,1: TDO pattern 0,1,0,1 (one-cycle bypass delay).
- Shift IR: first two TDO bits are 1,0 (capture 01). Load 4'b1001: user_sel=2'b10; in ShiDR, TDO follows user_tdo[1] and ShiftDR=1.
- From each of the 16 states, apply TMS=1 for 5 clocks: tap_state=0 every time, and ir_q reloads to 4'b0001.
- Assert TRSTN=0 mid-ShiIR after 2 bits of 4'b1111: tap_state=0 next cycle, ir_q=4'b0001, UpdateIR is never asserted.
- Load unassigned opcode 4'b0110: behaves as BYPASS, user_sel=0, CaptureDR/ShiftDR/UpdateDR stay 0 through a full DR scan.

Source files
------------

// File: rtl/jtag_tap_ctrl_pkg.sv
// Shared TAP definitions: state encodings, BYPASS opcode helper and IR capture pattern.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR      = 4'd0,
    IDLE     = 4'd1,
    SEL_DR   = 4'd2,
    CAP_DR   = 4'd3,
    SHI_DR   = 4'd4,
    EXIT1_DR = 4'd5,
    PAUSE_DR = 4'd6,
    EXIT2_DR = 4'd7,
    UPD_DR   = 4'd8,
    SEL_IR   = 4'd9,
    CAP_IR   = 4'd10,
    SHI_IR   = 4'd11,
    EXIT1_IR = 4'd12,
    PAUSE_IR = 4'd13,
    EXIT2_IR = 4'd14,
    UPD_IR   = 4'd15
  } tap_state_t;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

  // All-ones opcode of width w, right-aligned in 32 bits (the BYPASS opcode).
  function automatic logic [31:0] all_ones(input int unsigned w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/jtag_tap_ctrl_fsm.sv
// 16-state TAP state machine: state register plus next-state logic only.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCLK,
  input  logic       TRSTN,
  input  logic       TMS,
  output tap_state_t state
);

  tap_state_t state_nxt;

  always_ff @(posedge TCLK) begin
    if (!TRSTN) state <= TLR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      TLR:      state_nxt = TMS ? TLR      : IDLE;
      IDLE:     state_nxt = TMS ? SEL_DR   : IDLE;
      SEL_DR:   state_nxt = TMS ? SEL_IR   : CAP_DR;
      CAP_DR:   state_nxt = TMS ? EXIT1_DR : SHI_DR;
      SHI_DR:   state_nxt = TMS ? EXIT1_DR : SHI_DR;
      EXIT1_DR: state_nxt = TMS ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_nxt = TMS ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_nxt = TMS ? UPD_DR   : SHI_DR;
      UPD_DR:   state_nxt = TMS ? SEL_DR   : IDLE;
      SEL_IR:   state_nxt = TMS ? TLR      : CAP_IR;
      CAP_IR:   state_nxt = TMS ? EXIT1_IR : SHI_IR;
      SHI_IR:   state_nxt = TMS ? EXIT1_IR : SHI_IR;
      EXIT1_IR: state_nxt = TMS ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_nxt = TMS ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_nxt = TMS ? UPD_IR   : SHI_IR;
      UPD_IR:   state_nxt = TMS ? SEL_DR   : IDLE;
      default:  state_nxt = TLR;
    endcase
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: IR, BYPASS and IDCODE registers, instruction decode,
// user DR strobe gating and TDO mux around the TAP state machine.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int unsigned          IR_WIDTH     = 4,
  parameter logic [31:0]          IDCODE_VAL   = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0]  IDCODE_OP    = IR_WIDTH'(4'b0001),
  parameter int unsigned          NUM_USER     = 2,
  parameter logic [IR_WIDTH-1:0]  USER_OP_BASE = IR_WIDTH'(4'b1000)
) (
  input  logic                TCLK,
  input  logic                TRSTN,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_EN,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_q,
  output logic [NUM_USER-1:0] user_sel,
  output logic                CaptureDR,
  output logic                ShiftDR,
  output logic                UpdateDR,
  output logic                CaptureIR,
  output logic                ShiftIR,
  output logic                UpdateIR,
  input  logic [NUM_USER-1:0] user_tdo
);

  localparam logic [31:0] ONES_32   = all_ones(IR_WIDTH);
  localparam logic [31:0] USER_LAST = 32'(USER_OP_BASE) + 32'(NUM_USER) - 32'd1;

  // Parameter sanity: reject configurations that would alias opcodes.
  if (IR_WIDTH < 2) begin : g_err_irw
    $fatal(1, "jtag_tap_ctrl: IR_WIDTH must be at least 2");
  end
  if (NUM_USER < 1 || NUM_USER > 8) begin : g_err_nuser
    $fatal(1, "jtag_tap_ctrl: NUM_USER must be 1..8");
  end
  if (IDCODE_VAL[0] != 1'b1) begin : g_err_idval
    $fatal(1, "jtag_tap_ctrl: IDCODE_VAL bit 0 must be 1");
  end
  if (32'(IDCODE_OP) == ONES_32) begin : g_err_idop
    $fatal(1, "jtag_tap_ctrl: IDCODE_OP must not be the BYPASS opcode");
  end
  if (USER_LAST >= ONES_32) begin : g_err_urange
    $fatal(1, "jtag_tap_ctrl: user opcodes reach the BYPASS opcode");
  end
  if (32'(IDCODE_OP) >= 32'(USER_OP_BASE) && 32'(IDCODE_OP) <= USER_LAST) begin : g_err_overlap
    $fatal(1, "jtag_tap_ctrl: IDCODE_OP overlaps a user opcode");
  end

  tap_state_t          state;
  logic [IR_WIDTH-1:0] ir_shift;
  logic                bypass_q;
  logic [31:0]         idcode_shift;
  logic                sel_idcode;
  logic                sel_bypass;
  logic                user_any;

  jtag_tap_fsm u_fsm (
    .TCLK  (TCLK),
    .TRSTN (TRSTN),
    .TMS   (TMS),
    .state (state)
  );

  assign tap_state = 4'(state);

  // Instruction decode; unassigned opcodes fall back to BYPASS.
  always_comb begin
    user_sel = '0;
    for (int unsigned k = 0; k < NUM_USER; k++) begin
      if (ir_q == USER_OP_BASE + IR_WIDTH'(k)) user_sel[k] = 1'b1;
    end
    user_any   = |user_sel;
    sel_idcode = (ir_q == IDCODE_OP);
    sel_bypass = !sel_idcode && !user_any;
  end

  assign CaptureIR = (state == CAP_IR);
  assign ShiftIR   = (state == SHI_IR);
  assign UpdateIR  = (state == UPD_IR);
  assign CaptureDR = (state == CAP_DR) && user_any;
  assign ShiftDR   = (state == SHI_DR) && user_any;
  assign UpdateDR  = (state == UPD_DR) && user_any;
  assign TDO_EN    = (state == SHI_DR) || (state == SHI_IR);

  always_comb begin
    TDO = 1'b0;
    if (state == SHI_IR) begin
      TDO = ir_shift[0];
    end else if (state == SHI_DR) begin
      if (sel_idcode)    TDO = idcode_shift[0];
      else if (user_any) TDO = |(user_sel & user_tdo);
      else               TDO = bypass_q;
    end
  end

  // IR and built-in DRs; the capture/shift/update point is the clock leaving each state.
  always_ff @(posedge TCLK) begin
    if (!TRSTN) begin
      ir_q         <= IDCODE_OP;
      ir_shift     <= '0;
      bypass_q     <= 1'b0;
      idcode_shift <= '0;
    end else begin
      unique case (state)
        TLR:    ir_q     <= IDCODE_OP;
        CAP_IR: ir_shift <= IR_WIDTH'(IR_CAPTURE);
        SHI_IR: ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
        UPD_IR: ir_q     <= ir_shift;
        CAP_DR: begin
          if (sel_bypass) bypass_q     <= 1'b0;
          if (sel_idcode) idcode_shift <= IDCODE_VAL;
        end
        SHI_DR: begin
          if (sel_bypass) bypass_q     <= TDI;
          if (sel_idcode) idcode_shift <= {TDI, idcode_shift[31:1]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: IDCODE, BYPASS, user channel, TLR recovery, mid-shift reset.
module tb_jtag_tap_ctrl;

  logic       TCLK = 1'b0;
  logic       TRSTN = 1'b0;
  logic       TMS = 1'b1;
  logic       TDI = 1'b0;
  logic       TDO, TDO_EN;
  logic [3:0] tap_state;
  logic [3:0] ir_q;
  logic [1:0] user_sel;
  logic       CaptureDR, ShiftDR, UpdateDR, CaptureIR, ShiftIR, UpdateIR;
  logic [1:0] user_tdo = 2'b00;

  int errors = 0;
  int checks = 0;
  logic [2:0] strb_seen;
  logic       updir_seen;

  jtag_tap_ctrl dut (
    .TCLK      (TCLK),
    .TRSTN     (TRSTN),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO),
    .TDO_EN    (TDO_EN),
    .tap_state (tap_state),
    .ir_q      (ir_q),
    .user_sel  (user_sel),
    .CaptureDR (CaptureDR),
    .ShiftDR   (ShiftDR),
    .UpdateDR  (UpdateDR),
    .CaptureIR (CaptureIR),
    .ShiftIR   (ShiftIR),
    .UpdateIR  (UpdateIR),
    .user_tdo  (user_tdo)
  );

  always #5 TCLK = ~TCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One TCLK with the given TMS/TDI; outputs are sampled 1ns after the edge.
  task automatic tick(input logic tms_v, input logic tdi_v);
    TMS = tms_v;
    TDI = tdi_v;
    @(posedge TCLK);
    #1;
    strb_seen  = strb_seen | {UpdateDR, ShiftDR, CaptureDR};
    updir_seen = updir_seen | UpdateIR;
  endtask

  // From IDLE: load an IR value, return the TDO bits seen during the shift, back to IDLE.
  task automatic load_ir(input logic [3:0] val, output logic [3:0] seen);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      seen[i] = TDO;
      tick(i == 3, val[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // From IDLE: n-bit DR scan. upat drives user_tdo[1] (user_tdo[0] gets its inverse).
  task automatic shift_dr(input int n, input logic [31:0] tdi_v, input logic [31:0] upat,
                          output logic [31:0] seen);
    seen = '0;
    strb_seen = '0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      user_tdo = {upat[i], ~upat[i]};
      #1;
      seen[i] = TDO;
      if (i == 0) check("tdo_en_shidr", 32'(TDO_EN), 32'd1);
      tick(i == n - 1, tdi_v[i]);
    end
    user_tdo = 2'b00;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // TMS paths from TLR to each state, applied LSB first.
  logic [7:0] path_bits [16] = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h0A, 8'h0A, 8'h2A,
                                 8'h1A, 8'h06, 8'h06, 8'h06, 8'h16, 8'h16, 8'h56, 8'h36};
  int         path_len  [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};

  initial begin
    logic [3:0]  irs;
    logic [31:0] dr;
    logic [7:0]  pb;
    strb_seen  = '0;
    updir_seen = 1'b0;

    // Reset state
    tick(1'b1, 1'b0);
    check("rst_state", 32'(tap_state), 32'd0);
    check("rst_ir", 32'(ir_q), 32'h1);
    check("rst_user_sel", 32'(user_sel), 32'd0);
    check("rst_tdo", 32'({TDO, TDO_EN}), 32'd0);
    check("rst_strobes", 32'({CaptureDR, ShiftDR, UpdateDR, CaptureIR, ShiftIR, UpdateIR}), 32'd0);
    TRSTN = 1'b1;
    tick(1'b0, 1'b0);
    check("idle_state", 32'(tap_state), 32'd1);
    check("idle_tdo_en", 32'(TDO_EN), 32'd0);

    // IDCODE scan
    shift_dr(32, 32'h0, 32'h0, dr);
    check("idcode", dr, 32'h1000_0001);
    check("idcode_strobes", 32'(strb_seen), 32'd0);

    // BYPASS via all-ones opcode; TDI 1,0,1,1 -> TDO 0,1,0,1
    load_ir(4'b1111, irs);
    check("ir_capture", 32'(irs), 32'b0001);
    check("ir_bypass", 32'(ir_q), 32'hF);
    shift_dr(4, 32'b1101, 32'h0, dr);
    check("bypass_tdo", dr, 32'b1010);
    check("bypass_strobes", 32'(strb_seen), 32'd0);

    // User channel 1
    load_ir(4'b1001, irs);
    check("ir_user", 32'(ir_q), 32'h9);
    check("user_sel", 32'(user_sel), 32'b10);
    shift_dr(8, 32'h0, 32'hA6, dr);
    check("user_tdo", dr, 32'hA6);
    check("user_strobes", 32'(strb_seen), 32'b111);

    // Unassigned opcode behaves as BYPASS
    load_ir(4'b0110, irs);
    check("ir_unassigned", 32'(ir_q), 32'h6);
    check("unassigned_sel", 32'(user_sel), 32'd0);
    shift_dr(4, 32'b1101, 32'hFF, dr);
    check("unassigned_tdo", dr, 32'b1010);
    check("unassigned_strobes", 32'(strb_seen), 32'd0);

    // Reset during ShiIR after two bits of 1111
    updir_seen = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("midshift_in_shiir", 32'(tap_state), 32'd11);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    TRSTN = 1'b0;
    tick(1'b0, 1'b1);
    check("midshift_state", 32'(tap_state), 32'd0);
    check("midshift_ir", 32'(ir_q), 32'h1);
    check("midshift_no_updir", 32'(updir_seen), 32'd0);
    TRSTN = 1'b1;

    // TMS=1 x5 from every state reaches TLR; one more TLR clock reloads IR
    for (int s = 0; s < 16; s++) begin
      TRSTN = 1'b0;
      tick(1'b1, 1'b1);
      TRSTN = 1'b1;
      pb = path_bits[s];
      for (int b = 0; b < path_len[s]; b++) tick(pb[b], 1'b1);
      check($sformatf("reach_%0d", s), 32'(tap_state), 32'(s));
      for (int b = 0; b < 5; b++) tick(1'b1, 1'b1);
      check($sformatf("tlr_from_%0d", s), 32'(tap_state), 32'd0);
      tick(1'b1, 1'b1);
      check($sformatf("ir_reload_%0d", s), 32'(ir_q), 32'h1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
